// File: rtl/dst_scoreboard.sv
// dst_scoreboard: tracks the destination registers of the instructions in EX, MEM and WB,
// compares the ID sources against them, and produces the load-use stall and the
// registered EX operand forward selects.
// Optional feature macro: SCOREBOARD_FWD_EN
//   defined   -> forwarding from EX/MEM and MEM/WB, only load-use hazards stall
//   undefined -> forward selects tied to 00, any EX or MEM hazard stalls
module dst_scoreboard #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic [2:0]       id_dst_sel,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic [REG_W-1:0] ex_dst,
    output logic [REG_W-1:0] mem_dst,
    output logic [REG_W-1:0] wb_dst,
    output logic             ex_dv,
    output logic             mem_dv,
    output logic             wb_dv,
    output logic             sel_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
    localparam logic [REG_W-1:0] REG_RA   = REG_W'(5'd31);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic             ex_dv_r, mem_dv_r, wb_dv_r;
    logic [REG_W-1:0] ex_dst_r, mem_dst_r, wb_dst_r;
    logic             ex_ld_r;
    logic             sel_err_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic [REG_W-1:0] id_dst_s;
    logic             sel_ok_s;
    logic             new_v_s;
    logic             ex_hit_a_s, ex_hit_b_s, mem_hit_a_s, mem_hit_b_s;
    logic             ex_load_hit_s;
    logic             stall_raw_s;
    logic             stall_s;

    // The destination select is legal only when exactly one of rt / rd / $31 is chosen.
    function automatic logic sel_onehot(input logic [2:0] sel);
        logic ok;
        case (sel)
            3'b001, 3'b010, 3'b100: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // A source hits a stage when it is really read, is not $0, and names that stage's live destination.
    function automatic logic src_hit(input logic used, input logic [REG_W-1:0] idx,
                                     input logic dv, input logic [REG_W-1:0] dst);
        return used & (idx != REG_ZERO) & dv & (idx == dst);
    endfunction

    // Decode the one-hot destination select exactly as the write-back destination mux does.
    always_comb begin
        id_dst_s = REG_ZERO;
        case (id_dst_sel)
            3'b001:  id_dst_s = id_rt;
            3'b010:  id_dst_s = id_rd;
            3'b100:  id_dst_s = REG_RA;
            default: id_dst_s = REG_ZERO;
        endcase
    end

    assign sel_ok_s      = sel_onehot(id_dst_sel);
    assign ex_hit_a_s    = src_hit(id_rs_used, id_rs, ex_dv_r,  ex_dst_r);
    assign ex_hit_b_s    = src_hit(id_rt_used, id_rt, ex_dv_r,  ex_dst_r);
    assign mem_hit_a_s   = src_hit(id_rs_used, id_rs, mem_dv_r, mem_dst_r);
    assign mem_hit_b_s   = src_hit(id_rt_used, id_rt, mem_dv_r, mem_dst_r);
    assign ex_load_hit_s = ex_ld_r & (ex_hit_a_s | ex_hit_b_s);

    // Hazard detection; a flush or reset always wins over a pending stall.
    always_comb begin
        stall_raw_s = 1'b0;
`ifdef SCOREBOARD_FWD_EN
        stall_raw_s = ex_load_hit_s;
`else
        stall_raw_s = ex_load_hit_s | ex_hit_a_s | ex_hit_b_s | mem_hit_a_s | mem_hit_b_s;
`endif
        if (rst || flush) begin
            stall_s = 1'b0;
        end else begin
            stall_s = stall_raw_s;
        end
    end

    // Only an advancing, legal, register-writing instruction with a non-zero destination is tracked.
    assign new_v_s = id_valid & id_reg_write & ~flush & ~stall_s & sel_ok_s & (id_dst_s != REG_ZERO);

    // Shift the destination pipeline every cycle; EX takes the new entry or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_dv_r   <= 1'b0;
            ex_dst_r  <= REG_ZERO;
            ex_ld_r   <= 1'b0;
            mem_dv_r  <= 1'b0;
            mem_dst_r <= REG_ZERO;
            wb_dv_r   <= 1'b0;
            wb_dst_r  <= REG_ZERO;
        end else begin
            wb_dv_r   <= mem_dv_r;
            wb_dst_r  <= mem_dst_r;
            mem_dv_r  <= ex_dv_r;
            mem_dst_r <= ex_dst_r;
            ex_dv_r   <= new_v_s;
            ex_dst_r  <= new_v_s ? id_dst_s : REG_ZERO;
            ex_ld_r   <= new_v_s & id_mem_read;
        end
    end

`ifdef SCOREBOARD_FWD_EN
    logic [1:0] fwd_a_r, fwd_b_r;

    // The youngest producer wins: EX/MEM result before MEM/WB result, else the register file.
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        logic [1:0] sel;
        if (ex_hit) begin
            sel = 2'b01;
        end else if (mem_hit) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Capture operand selects as ID advances into EX; a bubble reads the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_r <= 2'b00;
            fwd_b_r <= 2'b00;
        end else if (stall_s || flush) begin
            fwd_a_r <= 2'b00;
            fwd_b_r <= 2'b00;
        end else begin
            fwd_a_r <= fwd_pick(ex_hit_a_s, mem_hit_a_s);
            fwd_b_r <= fwd_pick(ex_hit_b_s, mem_hit_b_s);
        end
    end

    assign ex_fwd_a = fwd_a_r;
    assign ex_fwd_b = fwd_b_r;
`else
    assign ex_fwd_a = 2'b00;
    assign ex_fwd_b = 2'b00;
`endif

    // Sticky record of an illegal destination select on a live register write.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_r <= 1'b0;
        end else if (id_valid && id_reg_write && !flush && !sel_ok_s) begin
            sel_err_r <= 1'b1;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall     = stall_s;
    assign ex_dv     = ex_dv_r;
    assign mem_dv    = mem_dv_r;
    assign wb_dv     = wb_dv_r;
    assign ex_dst    = ex_dst_r;
    assign mem_dst   = mem_dst_r;
    assign wb_dst    = wb_dst_r;
    assign sel_err   = sel_err_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_dst_scoreboard.sv
// Self-checking bench for dst_scoreboard: directed hazard scenarios followed by random
// instruction streams, all compared against an instruction-age reference model.
module tb_dst_scoreboard;

`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          id_rs_used, id_rt_used;
    logic [2:0]    id_dst_sel;
    logic          id_reg_write, id_mem_read, flush;
    logic          stall;
    logic [1:0]    ex_fwd_a, ex_fwd_b;
    logic [4:0]    ex_dst, mem_dst, wb_dst;
    logic          ex_dv, mem_dv, wb_dv;
    logic          sel_err;
    logic [CW-1:0] stall_cnt;

    dst_scoreboard #(.REG_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_dst_sel(id_dst_sel), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .stall(stall),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .ex_dv(ex_dv), .mem_dv(mem_dv), .wb_dv(wb_dv),
        .sel_err(sel_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    bit seen_stall;

    // Reference model: in-flight writers indexed by age (1 = EX, 2 = MEM, 3 = WB).
    bit         m_dv  [1:3];
    logic [4:0] m_dst [1:3];
    bit         m_ld1;
    logic [1:0] m_fa, m_fb;
    bit         m_err;
    int         m_cnt;
    bit         n_dv  [1:3];
    logic [4:0] n_dst [1:3];
    bit         n_ld1;
    logic [1:0] n_fa, n_fb;
    bit         n_err;
    int         n_cnt;
    bit         exp_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic used, input logic [4:0] idx, input int age);
        return used && (idx != 5'd0) && m_dv[age] && (m_dst[age] == idx);
    endfunction

    // Forward code equals the age of the youngest matching producer (EX = 1, MEM = 2).
    function automatic logic [1:0] want_fwd(input logic used, input logic [4:0] idx);
        logic [1:0] f;
        f = 2'b00;
        for (int age = 2; age >= 1; age--) begin
            if (FWD_EN && hit(used, idx, age)) f = 2'(age);
        end
        return f;
    endfunction

    task automatic model_eval();
        bit hit_ex, hit_mem, raw, one_hot, qual, go;
        logic [4:0] d;
        hit_ex  = hit(id_rs_used, id_rs, 1) || hit(id_rt_used, id_rt, 1);
        hit_mem = hit(id_rs_used, id_rs, 2) || hit(id_rt_used, id_rt, 2);
        raw       = FWD_EN ? (hit_ex && m_ld1) : (hit_ex || hit_mem);
        exp_stall = raw && !flush && !rst;
        one_hot   = ($countones(id_dst_sel) == 1);
        d = (id_dst_sel == 3'b001) ? id_rt : (id_dst_sel == 3'b010) ? id_rd : 5'd31;
        qual = id_valid && id_reg_write && !flush && !exp_stall && one_hot && (d != 5'd0);
        go   = !exp_stall && !flush;
        if (rst) begin
            for (int a = 1; a <= 3; a++) begin
                n_dv[a]  = 1'b0;
                n_dst[a] = 5'd0;
            end
            n_ld1 = 1'b0; n_fa = 2'b00; n_fb = 2'b00; n_err = 1'b0; n_cnt = 0;
        end else begin
            n_dv[3] = m_dv[2]; n_dst[3] = m_dst[2];
            n_dv[2] = m_dv[1]; n_dst[2] = m_dst[1];
            n_dv[1] = qual;    n_dst[1] = qual ? d : 5'd0;
            n_ld1   = qual && id_mem_read;
            n_fa    = go ? want_fwd(id_rs_used, id_rs) : 2'b00;
            n_fb    = go ? want_fwd(id_rt_used, id_rt) : 2'b00;
            n_err   = m_err || (id_valid && id_reg_write && !flush && !one_hot);
            n_cnt   = (exp_stall && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        end
    endtask

    task automatic model_commit();
        for (int a = 1; a <= 3; a++) begin
            m_dv[a]  = n_dv[a];
            m_dst[a] = n_dst[a];
        end
        m_ld1 = n_ld1; m_fa = n_fa; m_fb = n_fb; m_err = n_err; m_cnt = n_cnt;
    endtask

    task automatic check_state();
        check("ex_dv", ex_dv, m_dv[1]);
        if (m_dv[1]) check("ex_dst", ex_dst, m_dst[1]);
        check("mem_dv", mem_dv, m_dv[2]);
        if (m_dv[2]) check("mem_dst", mem_dst, m_dst[2]);
        check("wb_dv", wb_dv, m_dv[3]);
        if (m_dv[3]) check("wb_dst", wb_dst, m_dst[3]);
        check("ex_fwd_a", ex_fwd_a, m_fa);
        check("ex_fwd_b", ex_fwd_b, m_fb);
        check("sel_err", sel_err, m_err);
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    // One pipeline cycle: drive ID on the falling edge, check, then let the rising edge land.
    task automatic cyc(input logic v, input logic [4:0] rs, input logic ru,
                       input logic [4:0] rt, input logic tu, input logic [4:0] rd,
                       input logic [2:0] sel, input logic rw, input logic mr,
                       input logic fl, input logic r);
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rs_used = ru; id_rt = rt; id_rt_used = tu;
        id_rd = rd; id_dst_sel = sel; id_reg_write = rw; id_mem_read = mr;
        flush = fl; rst = r;
        #1;
        model_eval();
        if (chk_en) begin
            check("stall", stall, exp_stall);
            check_state();
        end
        seen_stall = stall;
        @(posedge clk);
        #1;
        model_commit();
    endtask

    task automatic nop();
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        repeat (2) cyc(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    // Present a reader until it is accepted (bounded), counting stall cycles.
    task automatic issue_reader(input logic [4:0] rs, input logic ru, input logic [4:0] rt,
                                input logic tu, output int nst);
        nst = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, rs, ru, rt, tu, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
            if (seen_stall) nst++;
            else break;
        end
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 5);
        if (r <= 3) return 5'(r);
        else if (r == 4) return 5'd31;
        else return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [2:0] pick_sel();
        int r;
        r = $urandom_range(0, 32);
        if (r < 31) return 3'(1 << (r % 3));
        else return 3'($urandom_range(0, 7));
    endfunction

    int nst;

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_dst_sel = 3'b001;
        id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            m_dv[a] = 1'b0; m_dst[a] = 5'd0;
        end
        m_ld1 = 1'b0; m_fa = 2'b00; m_fb = 2'b00; m_err = 1'b0; m_cnt = 0;

        // Reset with a live-looking ID instruction
        cyc(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_stall", seen_stall, 1'b0);
        check("rst_ex_dv", ex_dv, 1'b0);
        check("rst_wb_dv", wb_dv, 1'b0);
        check("rst_fwd_a", ex_fwd_a, 2'b00);
        check("rst_cnt", stall_cnt, 4'd0);

        // EX forward: add $8 then sub reading $8
        cyc(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        issue_reader(5'd8, 1'b1, 5'd0, 1'b0, nst);
        check("exfwd_stalls", nst, FWD_EN ? 0 : 2);
        check("exfwd_fwd_a", ex_fwd_a, FWD_EN ? 2'b01 : 2'b00);

        // Load-use: lw $9 then add reading $9 through rt
        do_reset();
        cyc(1'b1, 5'd4, 1'b1, 5'd9, 1'b0, 5'd0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
        issue_reader(5'd0, 1'b0, 5'd9, 1'b1, nst);
        check("lu_stalls", nst, FWD_EN ? 1 : 2);
        check("lu_fwd_b", ex_fwd_b, FWD_EN ? 2'b10 : 2'b00);
        check("lu_cnt", stall_cnt, FWD_EN ? 4'd1 : 4'd2);

        // $0 is never tracked; $31 from jal is
        do_reset();
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        check("r0_ex_dv", ex_dv, 1'b0);
        issue_reader(5'd0, 1'b1, 5'd0, 1'b1, nst);
        check("r0_stalls", nst, 0);
        check("r0_fwd_a", ex_fwd_a, 2'b00);
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
        check("jal_ex_dst", ex_dst, 5'd31);
        issue_reader(5'd31, 1'b1, 5'd0, 1'b0, nst);
        check("jal_stalls", nst, FWD_EN ? 0 : 2);
        check("jal_fwd_a", ex_fwd_a, FWD_EN ? 2'b01 : 2'b00);

        // Flush in the load-use stall cycle
        do_reset();
        cyc(1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 5'd0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fl_stall", seen_stall, 1'b0);
        check("fl_ex_dv", ex_dv, 1'b0);
        check("fl_cnt", stall_cnt, 4'd0);

        // Illegal select 011 writes nothing and latches sel_err
        do_reset();
        cyc(1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 5'd5, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bad_sel_err", sel_err, 1'b1);
        check("bad_ex_dv", ex_dv, 1'b0);
        issue_reader(5'd5, 1'b1, 5'd6, 1'b1, nst);
        check("bad_stalls", nst, 0);
        check("bad_fwd_a", ex_fwd_a, 2'b00);
        repeat (3) nop();
        check("bad_sticky", sel_err, 1'b1);

        // Stall counter saturation
        do_reset();
        repeat (20) begin
            cyc(1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 5'd0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
            cyc(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("sat_cnt", stall_cnt, 4'hF);

        // Random instruction streams
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic v;
            v = ($urandom_range(0, 9) != 0);
            cyc(v, pick_reg(), v & 1'($urandom_range(0, 1)),
                pick_reg(), v & 1'($urandom_range(0, 1)), pick_reg(), pick_sel(),
                1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 59) == 0));
        end
        nop();
        #1;
        check_state();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dst_scoreboard.md
# dst_scoreboard

- Tracks the destination registers of in-flight instructions in the EX, MEM and WB stages of the 5-stage pipeline.
- Compares the ID-stage source registers against those entries and drives the load-use stall and the registered EX-stage forwarding selects.
- It is the consumer side of the write-back destination choice: it decodes the same one-hot destination select (rt / rd / $31) that the destination mux uses.
- It sits beside the ID/EX pipeline register and is clocked with it.

## Interface

- REG_W, 5, register index width
- CNT_W, 16, stall performance counter width
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  REG_W  ID source register indices
- id_rs_used, id_rt_used  in  1  the corresponding source is actually read
- id_rd  in  REG_W  ID rd field
- id_dst_sel  in  3  one-hot destination select: 001 = rt, 010 = rd, 100 = 31
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  kill the ID instruction (branch/jump redirect)
- stall  out  1  hold PC and IF/ID, bubble into EX (combinational)
- ex_fwd_a, ex_fwd_b  out  2  registered EX operand selects: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result
- ex_dst, mem_dst, wb_dst  out  REG_W  tracked destination per stage
- ex_dv, mem_dv, wb_dv  out  1  entry valid per stage
- sel_err  out  1  sticky flag: a non-one-hot id_dst_sel was seen with id_reg_write
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation

**Entry creation**
- ID destination: id_rt for 001, id_rd for 010, 5'd31 for 100.
- An entry is valid only when id_valid & id_reg_write & !flush & !stall, the select is one-hot, and the destination is not 0.
- Register $0 is never tracked.
- The load bit is stored with the EX entry only.

**Shift, every cycle**
- WB <= MEM.
- MEM <= EX (the load bit is dropped).
- EX <= new entry, or a bubble (dv = 0) on stall, on flush, or when no entry qualifies.

**Match**
- A source matches a stage when its _used bit is 1, the index is not 0, the stage dv is 1, and the index equals the stage destination.

**Stall**
- stall = match against EX where the EX entry is a load.
- stall is suppressed when flush = 1.

**Forward selects, captured when ID advances (not stall, not flush)**
- EX match (non-load) -> 01.
- Else MEM match -> 10.
- Else -> 00.
- The EX match wins over the MEM match.
- A WB match needs no forward: the register file is write-through, so a WB write is visible to the same-cycle ID read.
- On stall or flush, ex_fwd_a and ex_fwd_b load 00 (bubble).

**sel_err**
- Set when id_valid & id_reg_write & !flush and id_dst_sel is not exactly one of 001 / 010 / 100.
- Such an instruction creates no entry.
- Cleared only by rst.

**stall_cnt**
- Increments on each cycle with stall = 1.
- Saturates at all-ones.

## Timing

- Reset (synchronous): every dv = 0, every *_dst = 0, ex_fwd_a = ex_fwd_b = 00, sel_err = 0, stall_cnt = 0.
- While rst is high, stall = 0.
- stall is combinational, valid in the same cycle as the ID inputs.
- ex_fwd_* are valid during the cycle the instruction occupies EX, i.e. one clock after ID.
- A load-use pair gives exactly one stall cycle.
  - In the next cycle the load is in MEM and the consumer re-evaluates to a MEM match, giving fwd 10.
- flush together with stall: flush wins, so stall = 0 and EX gets a bubble.
- The stall counter does not count that cycle.
- rst during a stall discards all entries; the next cycle has stall = 0.

## Configuration

SCOREBOARD_FWD_EN

**Defined**
- Forwarding as described above.
- Only load-use hazards stall.

**Undefined**
- ex_fwd_a and ex_fwd_b are tied to 00.
- stall = any source match against a valid EX or MEM entry, load or not.
- WB matches still never stall.
- Entry tracking, sel_err and stall_cnt are unchanged.

## Test plan

1. **Reset**
   - Stimulus: assert rst for 2 cycles with id_valid = 1.
   - Required: all dv = 0, fwd = 00, stall = 0, stall_cnt = 0.
2. **EX forward**
   - Stimulus: `add $8` (sel 010, rd = 8), then `sub` with rs = 8.
   - Required, FWD_EN: stall = 0, and ex_fwd_a = 01 in the cycle after the sub is in ID.
   - Required, no FWD_EN: 2 stall cycles, then ex_fwd_a = 00.
3. **Load-use**
   - Stimulus: `lw $9` (sel 001, rt = 9, mem_read), then `add` with rt = 9.
   - Required: stall = 1 for exactly 1 cycle, then ex_fwd_b = 10, and stall_cnt = 1.
4. **$0 and $31**
   - Stimulus: a write to $0, then a reader of $0.
   - Required: no entry, no stall, fwd 00.
   - Stimulus: `jal` (sel 100), then a reader of $31.
   - Required: ex_fwd_a = 01.
5. **Flush during stall**
   - Stimulus: a load-use pair with flush = 1 in the stall cycle.
   - Required: stall = 0, EX bubble (ex_dv = 0 next cycle), stall_cnt unchanged.
6. **Bad select**
   - Stimulus: id_dst_sel = 011 with id_reg_write = 1.
   - Required: sel_err = 1 next cycle and stays 1; no entry is created; a later reader of rd sees fwd 00.
